// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared frame size, command characters and transmitter state encoding
package uart_frame_pkg;
  localparam int DEF_FRAME_BYTES = 18;
  localparam logic [7:0] CMD_SEND_TX              = 8'h40;
  localparam logic [7:0] CMD_SHOOTING_FLAGS       = 8'h41;
  localparam logic [7:0] CMD_AES_KEY_STORE        = 8'h42;
  localparam logic [7:0] CMD_AES_PLAINTEXT_STORE  = 8'h43;
  localparam logic [7:0] CMD_PRIVILEGED_EXECUTOR  = 8'h44;
  localparam logic [7:0] CMD_DEV_READ_MEM_ADDRESS = 8'h61;
  localparam logic [7:0] CMD_DEV_READ_VALUES      = 8'h62;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
endpackage

// File: rtl/uart_frame_tx_baud.sv
// uart_baud_gen: oversample tick divider pulsing bit_end on the last clock of each bit time
module uart_baud_gen #(
  parameter int BR_LIMIT      = 672,
  parameter int BR_BITS       = 10,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr,
  output logic bit_end
);
  localparam int SUB_W = TICKS_PER_BIT > 1 ? $clog2(TICKS_PER_BIT) : 1;
  logic [BR_BITS-1:0] tick_q, tick_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic tick;
  assign tick    = tick_q == BR_BITS'(BR_LIMIT - 1);
  assign bit_end = tick && sub_q == SUB_W'(TICKS_PER_BIT - 1);
  always_comb begin
    tick_d = clr || tick ? '0 : tick_q + 1'b1;
    sub_d  = clr || bit_end ? '0 : tick ? sub_q + 1'b1 : sub_q;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tick_q <= '0;
      sub_q  <= '0;
    end else begin
      tick_q <= tick_d;
      sub_q  <= sub_d;
    end
  end
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: accepts a whole command frame and serialises it as back-to-back 8N1 bytes
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int FRAME_BYTES   = DEF_FRAME_BYTES,
  parameter int BR_LIMIT      = 672,
  parameter int BR_BITS       = 10,
  parameter int TICKS_PER_BIT = 16,
  parameter int STOP_BITS     = 1,
  parameter int AUTO_END      = 1
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [FRAME_BYTES*8-1:0] frame_i,
  input  logic                     frame_v_i,
  output logic                     ready_o,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int FW     = FRAME_BYTES * 8;
  localparam int BYTE_W = FRAME_BYTES > 1 ? $clog2(FRAME_BYTES) : 1;
  tx_state_e state_q, state_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic stop_q, stop_d;
  logic [FW-1:0] buf_q, buf_d, load;
  logic [7:0] cur_d;
  logic tx_q, tx_d;
  logic bit_end, accept, last_byte, last_stop;
  // the end character is forced to repeat the command character
  assign load      = AUTO_END != 0 ? {frame_i[7:0], frame_i[FW-9:0]} : frame_i;
  assign last_byte = byte_q == BYTE_W'(FRAME_BYTES - 1);
  assign last_stop = stop_q == 1'(STOP_BITS - 1);
  // ready during the final stop-bit cycle lets the next frame start with no idle gap
  assign done_o    = state_q == STOP && bit_end && last_stop && last_byte;
  assign busy_o    = state_q != IDLE && !done_o;
  assign ready_o   = !busy_o;
  assign accept    = frame_v_i && ready_o;
  assign tx_o      = tx_q;
  uart_baud_gen #(
    .BR_LIMIT     (BR_LIMIT),
    .BR_BITS      (BR_BITS),
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .nreset (nreset),
    .clr    (accept || state_q == IDLE),
    .bit_end(bit_end)
  );
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    buf_d   = buf_q;
    case (state_q)
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) begin
        stop_d = last_stop ? 1'b0 : stop_q + 1'b1;
        if (last_stop) begin
          state_d = last_byte ? IDLE : START;
          byte_d  = last_byte ? '0 : byte_q + 1'b1;
          buf_d   = buf_q >> 8;
        end
      end
      default: ;
    endcase
    if (accept) begin
      state_d = START;
      byte_d  = '0;
      bit_d   = '0;
      stop_d  = 1'b0;
      buf_d   = load;
    end
    cur_d = buf_d[7:0];
    tx_d  = state_d == START ? 1'b0 : state_d == DATA ? cur_d[bit_d] : 1'b1;
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      buf_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      buf_q   <= buf_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: randomized frames on three transmitter variants, decoded from the line and scored
module tb_uart_frame_tx;
  logic clk = 1'b0;
  logic nreset;
  logic [2:0] fv, tx, rdy, bsy, dn;
  logic [143:0] fw [3];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit act [3];
  bit bad [3];
  int cnt [3];
  int mk;
  logic [7:0] sh [3];
  logic [8:0] rx_mem [3][128];
  int st_mem [3][128];
  int rx_n [3];
  int done_n [3];
  int done_cyc [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_frame_tx #(
      .FRAME_BYTES  (18),
      .BR_LIMIT     (2),
      .BR_BITS      (2),
      .TICKS_PER_BIT(2),
      .STOP_BITS    (g == 2 ? 2 : 1),
      .AUTO_END     (g == 1 ? 0 : 1)
    ) dut (
      .clk      (clk),
      .nreset   (nreset),
      .frame_i  (fw[g]),
      .frame_v_i(fv[g]),
      .ready_o  (rdy[g]),
      .tx_o     (tx[g]),
      .busy_o   (bsy[g]),
      .done_o   (dn[g])
    );
  end

  function automatic int sbits(input int i);
    return i == 2 ? 2 : 1;
  endfunction

  function automatic bit aend(input int i);
    return i != 1;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [143:0] f, input int n, input bit ae);
    if (ae && n == 17) return f[7:0];
    return f[8*n +: 8];
  endfunction

  function automatic logic [143:0] rnd_frame();
    logic [143:0] f;
    for (int n = 0; n < 18; n++) f[8*n +: 8] = 8'($urandom);
    return f;
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // line decoder: 4 clocks per bit, sampled mid-bit, framing errors flagged in bit 8
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dn[i]) begin
        done_n[i]++;
        done_cyc[i] = cyc;
      end
      if (!nreset) act[i] = 1'b0;
      else if (!act[i]) begin
        if (!tx[i]) begin
          act[i] = 1'b1;
          cnt[i] = 0;
          bad[i] = 1'b0;
          if (rx_n[i] < 128) st_mem[i][rx_n[i]] = cyc;
        end
      end else begin
        cnt[i]++;
        if (cnt[i] % 4 == 2) begin
          mk = cnt[i] / 4;
          if (mk >= 1 && mk <= 8) sh[i][mk-1] = tx[i];
          else if (tx[i] != (mk != 0)) bad[i] = 1'b1;
        end
        if (cnt[i] == (9 + sbits(i)) * 4 - 1) begin
          if (rx_n[i] < 128) rx_mem[i][rx_n[i]] = {bad[i], sh[i]};
          rx_n[i]++;
          act[i] = 1'b0;
        end
      end
    end
  end

  task automatic offer(input int i, input logic [143:0] f, input int bound, output int acc);
    acc = -1;
    fw[i] = f;
    fv[i] = 1'b1;
    for (int k = 0; k < bound && acc < 0; k++) begin
      if (rdy[i]) acc = cyc + 1;
      @(negedge clk);
    end
    fv[i] = 1'b0;
    fw[i] = rnd_frame();
    check("accepted", acc >= 0, 1);
  endtask

  task automatic wait_done(input int i, input int d0);
    for (int k = 0; k < 1000 && done_n[i] == d0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input int i, input logic [143:0] f, input int r0, input int acc);
    int len = (9 + sbits(i)) * 4;
    for (int n = 0; n < 18; n++) begin
      check($sformatf("dut%0d_byte%0d", i, n), rx_mem[i][r0+n], {1'b0, exp_byte(f, n, aend(i))});
      check($sformatf("dut%0d_start%0d", i, n), st_mem[i][r0+n], acc + n * len);
    end
  endtask

  task automatic run_frame(input int i, input logic [143:0] f);
    int r0 = rx_n[i];
    int d0 = done_n[i];
    int acc;
    int len = 18 * (9 + sbits(i)) * 4;
    offer(i, f, 50, acc);
    check("busy_up", bsy[i], 1);
    check("ready_down", rdy[i], 0);
    wait_done(i, d0);
    check("done_once", done_n[i] - d0, 1);
    check("done_cyc", done_cyc[i], acc + len - 1);
    check("byte_count", rx_n[i] - r0, 18);
    check_frame(i, f, r0, acc);
    check("end_tx_idle", tx[i], 1);
    check("end_ready", rdy[i], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [143:0] f, fa, fb;
    int acc, acc_a, acc_b, r0, d0;
    nreset = 1'b0;
    fv = '0;
    for (int i = 0; i < 3; i++) begin
      fw[i] = '0;
      act[i] = 1'b0;
      rx_n[i] = 0;
      done_n[i] = 0;
      done_cyc[i] = -1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_tx", tx[i], 1);
      check("rst_ready", rdy[i], 1);
      check("rst_busy", bsy[i], 0);
      check("rst_done", dn[i], 0);
    end
    nreset = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) check("idle_tx", tx[i], 1);

    f = rnd_frame();
    f[7:0] = 8'h40;
    f[15:8] = 8'h41;
    f[143:136] = 8'h00;
    run_frame(0, f);

    fa = rnd_frame();
    fb = rnd_frame();
    fb[7:0] = 8'h42;
    r0 = rx_n[0];
    d0 = done_n[0];
    offer(0, fa, 50, acc_a);
    offer(0, fb, 900, acc_b);
    check("b2b_done_a", done_cyc[0], acc_a + 719);
    check("b2b_latch", acc_b, done_cyc[0] + 1);
    wait_done(0, d0 + 1);
    check("b2b_done_n", done_n[0] - d0, 2);
    check("b2b_bytes", rx_n[0] - r0, 36);
    check("b2b_gap", st_mem[0][r0+18], acc_a + 720);
    check("b2b_done_b", done_cyc[0], acc_b + 719);
    check_frame(0, fa, r0, acc_a);
    check_frame(0, fb, r0 + 18, acc_b);

    f = rnd_frame();
    f[43] = 1'b0;
    r0 = rx_n[0];
    d0 = done_n[0];
    offer(0, f, 50, acc);
    while (cyc < acc + 217) @(negedge clk);
    check("pre_rst_tx", tx[0], 0);
    #2 nreset = 1'b0;
    #1;
    check("arst_tx", tx[0], 1);
    check("arst_ready", rdy[0], 1);
    check("arst_busy", bsy[0], 0);
    check("arst_done", dn[0], 0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done", done_n[0] - d0, 0);
    check("rst_partial", rx_n[0] - r0, 5);
    f = rnd_frame();
    f[7:0] = 8'h43;
    run_frame(0, f);

    f = rnd_frame();
    f[7:0] = 8'h44;
    f[143:136] = 8'h7D;
    run_frame(1, f);
    f = rnd_frame();
    f[7:0] = 8'h61;
    run_frame(1, f);

    f = rnd_frame();
    f[7:0] = 8'h62;
    run_frame(2, f);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
